mandala_sequencer: RTL
======================

# mandala_sequencer

Frame-level animation scheduler for the mandala VGA demo. It watches the sync generator's vsync and produces the animation counters consumed by the pattern/colour datapath: pattern, colour and glitter phase, plus scene index and fade level. It adds pause, single-step, speed, direction and scene-hold control from the user inputs. It sits between the top-level `ui_in` pins, the hvsync generator and the pattern logic, replacing free-running per-frame counters.

## Interface
Parameters:
- `NUM_SCENES`, 6: number of scenes; `scene` wraps modulo this value. Range 2..8.
- `SCENE_TICKS`, 240: animation ticks per scene before the fade sequence starts. Must be ≥ 1.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  synchronous, active-high reset.
- `vsync`  in  1  vsync from the sync generator. A rising edge is the frame event.
- `pause_req`  in  1  level; 1 requests pause.
- `step_req`  in  1  rising edge requests one animation tick while paused.
- `speed`  in  2  animation divider: one animation tick every 2^speed frames (1, 2, 4, 8).
- `dir`  in  1  0 = counters increment, 1 = decrement.
- `scene_hold`  in  1  1 freezes the scene timer.
- `pattern_ctr`  out  10  pattern phase.
- `color_ctr`  out  8  colour phase.
- `glitter_ctr`  out  16  glitter phase.
- `scene`  out  3  current scene index.
- `fade`  out  3  brightness level; 7 = full, 0 = black.
- `state`  out  2  0 = RUN, 1 = PAUSED, 2 = FADE_OUT, 3 = FADE_IN.
- `frame_tick`  out  1  one-cycle pulse marking that outputs were updated for a new frame.

## Operation
- Frame event E: `vsync`==1 and `vsync_q`==0 in a cycle, where `vsync_q` is `vsync` registered. All state updates happen only at the clock edge ending a cycle with E.
- Frame divider `fdiv` (3 bit): at each E in RUN/FADE states, the animation tick A fires if `fdiv` ≥ 2^speed−1. When A fires, `fdiv` is set to 0; otherwise it increments. Lowering `speed` therefore fires at the next E.
- On A: `pattern_ctr` and `color_ctr` each change by +1 (`dir`=0) or −1 (`dir`=1), wrapping modulo 2^width.
- `glitter_ctr` increments by 1 at every E except in PAUSED, independent of `speed` and `dir`.
- Scene timer `stmr` (9 bit) counts A in RUN only, and only when `scene_hold`=0. When an A occurs with `stmr`==SCENE_TICKS−1, `stmr` goes to 0 and the state goes to FADE_OUT.
- FSM, evaluated at E:
  - RUN: scene end goes to FADE_OUT; this has priority over pause. Else `pause_req`=1 goes to PAUSED.
  - FADE_OUT: `fade` decrements each E. At the E where `fade`==0: `scene` = (`scene`+1) mod NUM_SCENES, then go to FADE_IN.
  - FADE_IN: `fade` increments each E. At the E where `fade`==7, go to RUN. Pause is ignored during both fades.
  - PAUSED: all counters frozen. If a step is pending, apply one A (ignoring `fdiv`, `stmr` unchanged) and clear the step. `pause_req`=0 goes to RUN, with `fdiv` reset to 0.
- Step: a `step_req` rising edge sets `step_pend`. Further edges before consumption are merged into it. `step_pend` is cleared at any E not in PAUSED.

## Timing
- Reset values: all counters 0, `scene` 0, `fade` 7, `state` RUN, `frame_tick` 0, `fdiv` 0, `stmr` 0, `step_pend` 0.
- `vsync_q` resets to 1, so a `vsync` held high through reset release produces no spurious E.
- All outputs are registered. With E in cycle n, outputs change at the edge ending cycle n, and `frame_tick`=1 during cycle n+1 only.
- The first E after reset with `speed`=0 gives `pattern_ctr`=1.
- Reset asserted mid-fade or mid-pause restores reset values on the next edge. No residual pending step survives reset.
- A vsync pulse of any length ≥1 cycle gives exactly one E. Inputs other than `vsync` and `step_req` are sampled at E only.

## Test plan
- Reset, `speed`=0, `dir`=0, 3 vsync pulses → `pattern_ctr`=3, `color_ctr`=3, `glitter_ctr`=3, exactly 3 `frame_tick` pulses, each one cycle after the E cycle.
- `speed`=2, 8 frames → `pattern_ctr`=2, `glitter_ctr`=8. Then `dir`=1 for 4 frames → `pattern_ctr`=1. Then from 0, one decrement → `pattern_ctr`=1023, `color_ctr`=255.
- SCENE_TICKS=4, NUM_SCENES=2: 4 frames → `state`=FADE_OUT. 8 more frames → `fade` 6..0, `scene`=1, FADE_IN. 8 more → `fade`=7, RUN. A second cycle → `scene` wraps to 0.
- `pause_req`=1 at frame 2 → PAUSED, counters frozen over 5 frames. Two `step_req` edges in one frame → exactly +1 `pattern_ctr`. `pause_req`=0 → RUN, and counting resumes next E.
- `pause_req`=1 asserted in the same frame as scene end → FADE_OUT entered, pause deferred. After FADE_IN completes → PAUSED.
- `vsync` held high across reset release → no `frame_tick`. Reset pulsed mid-FADE_OUT → `fade`=7, `scene`=0, `state`=RUN.

Source files
------------

// File: rtl/mandala_sequencer.sv
// mandala_sequencer
// -----------------------------------------------------------------------------
// Frame-level animation scheduler for the mandala VGA demo. Each rising edge
// of vsync is one frame event; at that event the block advances the pattern,
// colour and glitter phases, runs the scene timer and the fade-out/fade-in
// sequence between scenes, and applies pause / single-step / speed / direction
// / scene-hold control coming from the user inputs.
//
// Ports
//   clk          pixel clock
//   reset        synchronous, active-high reset
//   vsync        vsync from the sync generator (rising edge = frame event)
//   pause_req    level, 1 requests pause
//   step_req     rising edge requests one animation tick while paused
//   speed[1:0]   one animation tick every 2^speed frames
//   dir          0 = phases increment, 1 = phases decrement
//   scene_hold   1 freezes the scene timer
//   pattern_ctr  pattern phase (10 bit)
//   color_ctr    colour phase (8 bit)
//   glitter_ctr  glitter phase (16 bit), advances every non-paused frame
//   scene        current scene index
//   fade         brightness level, 7 = full, 0 = black
//   state        0 RUN, 1 PAUSED, 2 FADE_OUT, 3 FADE_IN
//   frame_tick   one-cycle pulse, outputs were just updated for a new frame
// -----------------------------------------------------------------------------
module mandala_sequencer #(
  parameter int NUM_SCENES  = 6,
  parameter int SCENE_TICKS = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        pause_req,
  input  logic        step_req,
  input  logic [1:0]  speed,
  input  logic        dir,
  input  logic        scene_hold,
  output logic [9:0]  pattern_ctr,
  output logic [7:0]  color_ctr,
  output logic [15:0] glitter_ctr,
  output logic [2:0]  scene,
  output logic [2:0]  fade,
  output logic [1:0]  state,
  output logic        frame_tick
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_PAUSED   = 2'd1,
    ST_FADE_OUT = 2'd2,
    ST_FADE_IN  = 2'd3
  } state_t;

  localparam logic [2:0] LAST_SCENE = 3'(NUM_SCENES - 1);
  localparam logic [8:0] LAST_TICK  = 9'(SCENE_TICKS - 1);

  state_t      state_q, state_d;
  logic        vsync_q;
  logic        step_req_q;
  logic        step_pend_q, step_pend_d;
  logic [2:0]  fdiv_q, fdiv_d;
  logic [8:0]  stmr_q, stmr_d;
  logic [9:0]  pattern_q, pattern_d;
  logic [7:0]  color_q, color_d;
  logic [15:0] glitter_q, glitter_d;
  logic [2:0]  scene_q, scene_d;
  logic [2:0]  fade_q, fade_d;
  logic        frame_tick_q;

  logic        frame_ev;
  logic        step_rise;
  logic [2:0]  tick_thresh;
  logic        anim_tick;
  logic        scene_end;
  logic [9:0]  pattern_adv;
  logic [7:0]  color_adv;

  assign frame_ev  = vsync & ~vsync_q;
  assign step_rise = step_req & ~step_req_q;

  // 2^speed - 1: the divider value at which the animation tick fires.
  always_comb begin
    tick_thresh = 3'd0;
    case (speed)
      2'd0: tick_thresh = 3'd0;
      2'd1: tick_thresh = 3'd1;
      2'd2: tick_thresh = 3'd3;
      2'd3: tick_thresh = 3'd7;
      default: tick_thresh = 3'd0;
    endcase
  end

  // ">=" rather than "==" so that lowering speed fires on the next frame
  // instead of waiting for the divider to wrap.
  assign anim_tick = (fdiv_q >= tick_thresh);

  assign pattern_adv = dir ? (pattern_q - 10'd1) : (pattern_q + 10'd1);
  assign color_adv   = dir ? (color_q - 8'd1)    : (color_q + 8'd1);

  assign scene_end = anim_tick & ~scene_hold & (stmr_q == LAST_TICK);

  always_comb begin
    state_d     = state_q;
    fdiv_d      = fdiv_q;
    stmr_d      = stmr_q;
    pattern_d   = pattern_q;
    color_d     = color_q;
    glitter_d   = glitter_q;
    scene_d     = scene_q;
    fade_d      = fade_q;
    // Step requests accumulate between frames; repeated edges merge.
    step_pend_d = step_pend_q | step_rise;

    if (frame_ev) begin
      if (state_q == ST_PAUSED) begin
        // Single step: one animation tick, divider and scene timer untouched.
        if (step_pend_q) begin
          pattern_d   = pattern_adv;
          color_d     = color_adv;
          step_pend_d = step_rise;
        end
        if (!pause_req) begin
          state_d = ST_RUN;
          fdiv_d  = 3'd0;
        end
      end else begin
        // Steps only mean something while paused; drop stale ones here.
        step_pend_d = 1'b0;
        glitter_d   = glitter_q + 16'd1;

        if (anim_tick) begin
          fdiv_d    = 3'd0;
          pattern_d = pattern_adv;
          color_d   = color_adv;
        end else begin
          fdiv_d = fdiv_q + 3'd1;
        end

        case (state_q)
          ST_RUN: begin
            if (anim_tick && !scene_hold) begin
              stmr_d = scene_end ? 9'd0 : (stmr_q + 9'd1);
            end
            // Scene end wins over pause; the pause is picked up after the fades.
            if (scene_end) begin
              state_d = ST_FADE_OUT;
            end else if (pause_req) begin
              state_d = ST_PAUSED;
            end
          end
          ST_FADE_OUT: begin
            // Hold one frame at black, then switch scene and fade back in.
            if (fade_q == 3'd0) begin
              scene_d = (scene_q == LAST_SCENE) ? 3'd0 : (scene_q + 3'd1);
              state_d = ST_FADE_IN;
            end else begin
              fade_d = fade_q - 3'd1;
            end
          end
          ST_FADE_IN: begin
            if (fade_q == 3'd7) begin
              state_d = ST_RUN;
            end else begin
              fade_d = fade_q + 3'd1;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      // Resetting the vsync history high suppresses a false frame event when
      // vsync is already high as reset is released.
      vsync_q      <= 1'b1;
      step_req_q   <= 1'b1;
      step_pend_q  <= 1'b0;
      fdiv_q       <= 3'd0;
      stmr_q       <= 9'd0;
      pattern_q    <= 10'd0;
      color_q      <= 8'd0;
      glitter_q    <= 16'd0;
      scene_q      <= 3'd0;
      fade_q       <= 3'd7;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync;
      step_req_q   <= step_req;
      step_pend_q  <= step_pend_d;
      fdiv_q       <= fdiv_d;
      stmr_q       <= stmr_d;
      pattern_q    <= pattern_d;
      color_q      <= color_d;
      glitter_q    <= glitter_d;
      scene_q      <= scene_d;
      fade_q       <= fade_d;
      frame_tick_q <= frame_ev;
    end
  end

  assign pattern_ctr = pattern_q;
  assign color_ctr   = color_q;
  assign glitter_ctr = glitter_q;
  assign scene       = scene_q;
  assign fade        = fade_q;
  assign state       = state_q;
  assign frame_tick  = frame_tick_q;

endmodule
